// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for serial_adder: operands in, busy/done/result out.
// SERIAL_ADDER_OVF_EN adds the signed-overflow flag to the bundle.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, DIGIT bits per clock through chained full adders.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
//
// state  | meaning
// IDLE   | waiting for start, operands captured on accept
// RUN    | one digit of the result produced per cycle
// DONE   | one-cycle done pulse, result valid
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, sub_q, sub_d, cout_q, cout_d;
    logic [DIGIT-1:0] dig_s;
    logic             dig_c;
    logic             last_digit;
    logic             busy, done;
`ifdef SERIAL_ADDER_OVF_EN
    logic             dig_c_msb;
    logic             ovf_q, ovf_d;
`endif

    task automatic full_add(input logic x, input logic y, input logic ci,
                            output logic s, output logic co);
        s  = x ^ y ^ ci;
        co = (x & y) | (ci & (x ^ y));
    endtask

    always_comb begin : p_digit
        logic [DIGIT:0] c;
        c     = '0;
        c[0]  = carry_q;
        dig_s = '0;
        for (int i = 0; i < DIGIT; i++) begin
            full_add(a_q[i], b_q[i], c[i], dig_s[i], c[i+1]);
        end
        dig_c = c[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
        dig_c_msb = c[DIGIT-1];
`endif
    end

    assign last_digit = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (last_digit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // Subtraction runs as a + ~b + ~borrow_in; the borrow-out is the inverted final carry.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    sub_d   = bus.sub;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = (WIDTH'(dig_s) << (WIDTH - DIGIT)) | (res_q >> DIGIT);
                carry_d = dig_c;
                cnt_d   = cnt_q + 1'b1;
                if (last_digit) begin
                    sum_d  = res_d;
                    cout_d = dig_c ^ sub_q;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d  = dig_c ^ dig_c_msb;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: five WIDTH/DIGIT builds, each checked every cycle against
// an arithmetic model, plus directed vectors with hand-computed results.
module tb_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  start_v = '0;
    logic [7:0]  a_s = '0, b_s = '0;
    logic        cin_s = 1'b0, sub_s = 1'b0;
    logic [4:0]  done_v, busy_v, cout_v, ovf_v;
    logic [39:0] sum_flat;
    bit          chk_en = 1'b0;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d]: got %0h expected %0h at %0t", nm, g, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int W = (g < 2) ? 8 : 4;
        localparam int D = (g == 1) ? 2 : (g == 3) ? 2 : (g == 4) ? 4 : 1;
        localparam int N = W / D;

        serial_adder_if #(.WIDTH(W)) bus ();
        serial_adder #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

        assign bus.start = start_v[g];
        assign bus.a     = a_s[W-1:0];
        assign bus.b     = b_s[W-1:0];
        assign bus.cin   = cin_s;
        assign bus.sub   = sub_s;
        assign done_v[g] = bus.done;
        assign busy_v[g] = bus.busy;
        assign cout_v[g] = bus.cout;
        assign sum_flat[g*8 +: 8] = 8'(bus.sum);
`ifdef SERIAL_ADDER_OVF_EN
        assign ovf_v[g] = bus.ovf;
`else
        assign ovf_v[g] = 1'b0;
`endif

        // returns {ovf, cout, sum} from plain integer arithmetic
        function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic ci, input logic s);
            int ux, uy, sx, sy, r, sr;
            logic co, ov;
            ux = int'(x);
            uy = int'(y);
            sx = $signed(x);
            sy = $signed(y);
            if (!s) begin
                r  = ux + uy + int'(ci);
                co = (r >= (1 << W));
                sr = sx + sy + int'(ci);
            end else begin
                r  = ux - uy - int'(ci);
                co = (ux < uy + int'(ci));
                sr = sx - sy - int'(ci);
            end
            ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
            return {ov, co, r[W-1:0]};
        endfunction

        int             phase = 0;
        logic [W+1:0]   pend = '0;
        logic [W+1:0]   expv = '0;

        always @(posedge clk) begin
            if (!rst_n) begin
                phase <= 0;
                expv  <= '0;
            end else if (phase == 0) begin
                if (bus.start) begin
                    phase <= 1;
                    pend  <= ref_op(bus.a, bus.b, bus.cin, bus.sub);
                end
            end else if (phase == N) begin
                phase <= N + 1;
                expv  <= pend;
            end else if (phase == N + 1) begin
                phase <= 0;
            end else begin
                phase <= phase + 1;
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                chk("busy", g, 32'(bus.busy), 32'(phase >= 1 && phase <= N));
                chk("done", g, 32'(bus.done), 32'(phase == N + 1));
                if (phase == 0 || phase == N + 1) begin
                    chk("sum", g, 32'(bus.sum), 32'(expv[W-1:0]));
                    chk("cout", g, 32'(bus.cout), 32'(expv[W]));
`ifdef SERIAL_ADDER_OVF_EN
                    chk("ovf", g, 32'(bus.ovf), 32'(expv[W+1]));
`endif
                end
            end
        end
    end

    task automatic go(input int g, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input logic sb, output int k);
        @(negedge clk);
        a_s = av; b_s = bv; cin_s = ci; sub_s = sb;
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        a_s = 8'($urandom); b_s = 8'($urandom);
        cin_s = 1'($urandom); sub_s = 1'($urandom);
        k = 1;
        while (!done_v[g] && k < 64) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", g, 32'(done_v[g]), 32'd1);
        @(negedge clk);
    endtask

    task automatic op(input int g, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                      input logic sb, input logic [7:0] es, input logic ec, input int lat);
        int k;
        go(g, av, bv, ci, sb, k);
        chk("latency", g, 32'(k), 32'(lat));
        chk("lit_sum", g, 32'(sum_flat[g*8 +: 8]), 32'(es));
        chk("lit_cout", g, 32'(cout_v[g]), 32'(ec));
    endtask

    initial begin
        int k, last, cyc;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op(0, 8'h5A, 8'h3C, 1'b0 | 1'b1, 1'b0, 8'h97, 1'b0, 9);
        op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 9);
`ifdef SERIAL_ADDER_OVF_EN
        chk("lit_ovf", 0, 32'(ovf_v[0]), 32'd0);
`endif
        op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 9);
`ifdef SERIAL_ADDER_OVF_EN
        chk("lit_ovf", 0, 32'(ovf_v[0]), 32'd1);
`endif
        op(1, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1, 5);
        op(1, 8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b0, 5);

        // start held high with operands changing every cycle
        last = -1;
        start_v[0] = 1'b1;
        for (cyc = 0; cyc < 36; cyc++) begin
            @(negedge clk);
            if (done_v[0]) begin
                if (last >= 0) chk("period", 0, 32'(cyc - last), 32'd10);
                last = cyc;
            end
            a_s = 8'($urandom); b_s = 8'($urandom);
            cin_s = 1'($urandom); sub_s = 1'($urandom);
        end
        start_v[0] = 1'b0;
        repeat (12) @(negedge clk);

        // reset during the third RUN cycle
        a_s = 8'h55; b_s = 8'h22; cin_s = 1'b0; sub_s = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("rst_done", 0, 32'(done_v[0]), 32'd0);
        chk("rst_sum", 0, 32'(sum_flat[7:0]), 32'd0);
        chk("rst_cout", 0, 32'(cout_v[0]), 32'd0);
        rst_n = 1'b1;
        op(0, 8'd3, 8'd4, 1'b0, 1'b0, 8'd7, 1'b0, 9);

        // exhaustive 4-bit sweep on the three DIGIT variants
        for (int g = 2; g < 5; g++) begin
            for (int s = 0; s < 2; s++)
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++)
                        for (int c = 0; c < 2; c++)
                            go(g, 8'(x), 8'(y), 1'(c), 1'(s), k);
        end
        op(4, 8'h3, 8'h5, 1'b1, 1'b1, 8'hD, 1'b1, 2);
        op(3, 8'h9, 8'h8, 1'b1, 1'b0, 8'h2, 1'b1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor built on the full-adder task. It accepts two WIDTH-bit operands and a carry-in under a start/done handshake. It processes DIGIT bits per clock through a chain of DIGIT full-adder task calls, with the carry registered between cycles. It is the area-optimised successor to the single-bit combinational full adder, for datapaths where multi-cycle latency is acceptable.

## Interface
Parameters:
- WIDTH, 8, operand/result width; ≥ 2.
- DIGIT, 1, bits processed per clock; must divide WIDTH exactly (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in (add) / borrow-in (subtract); captured on accepted start.
- sub  input  1  0 = add, 1 = subtract; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held stable between done and the next accepted start.
- cout  output  1  carry-out (add) / borrow-out (subtract).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1. Capture the following:
  - a into shift register A.
  - b into shift register B, inverted when sub=1.
  - carry register <= cin XOR sub.
  - digit counter <= 0.
  - busy <= 1.
- RUN, each cycle:
  - Feed the low DIGIT bits of A and B and the carry register through DIGIT chained full-adder task calls, LSB first.
  - Shift the DIGIT result bits into the top of the result register.
  - Shift A and B right by DIGIT.
  - Register the final carry and increment the counter.
- RUN -> DONE after the cycle where the counter reaches WIDTH/DIGIT−1.
- DONE (one cycle):
  - done = 1, busy = 0.
  - sum = result register.
  - cout = carry when sub=0, ~carry when sub=1 (borrow).
  - Next state: IDLE.
- Arithmetic:
  - Add: {cout,sum} = a + b + cin.
  - Subtract: sum = (a − b − cin) mod 2^WIDTH; cout = 1 iff a < b + cin (unsigned).
- Boundaries and simultaneous events:
  - start while busy or in DONE is ignored, not queued.
  - a/b/cin/sub changes after capture have no effect on the operation in progress.
  - rst_n=0 at any cycle, mid-RUN included: return to IDLE at that edge and discard the partial result.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, FSM=IDLE, counter=0.
- Counting from the edge E0 that samples start=1 in IDLE:
  - busy is high after E0 through edge E(N), with N = WIDTH/DIGIT.
  - done is high for exactly the one cycle after E(N).
- Latency start-to-done is N+1 clocks.
- Earliest next accepted start is the edge ending the DONE cycle, so throughput is one operation per N+2 clocks.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0, updated with sum at DONE and held until the next DONE.
  - ovf = signed two's-complement overflow = carry into the MSB XOR carry out of the MSB (pre-borrow-inversion).
- Undefined: ovf port is absent and no extra logic is generated.

## Test plan
- WIDTH=8, DIGIT=1; add a=0x5A, b=0x3C, cin=1 -> done exactly 9 clocks after start, sum=0x97, cout=0.
- WIDTH=8, DIGIT=1; add a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. With SERIAL_ADDER_OVF_EN, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, ovf=1.
- WIDTH=8, DIGIT=2; subtract a=0x10, b=0x20, cin=0 -> done 5 clocks after start, sum=0xF0, cout=1 (borrow). Then a=0x20, b=0x10, cin=1 -> sum=0x0F, cout=0.
- Start held high continuously, operands changed every cycle -> only the operands at accepted starts are used; done pulses every N+2 clocks; results match the captured operands.
- rst_n=0 for one cycle at the 3rd RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0. A subsequent start of a=3, b=4 yields sum=7 with no corruption.
- Exhaustive WIDTH=4, DIGIT ∈ {1,2,4}, both modes, all a/b/cin -> sum/cout (and ovf when enabled) match the arithmetic reference every time.
